// File: rtl/serial_adder.sv
//==============================================================================
// Module   : serial_adder
// Brief    : Digit-serial add/subtract unit with valid/ready on both sides.
// Revision : 1.0
//==============================================================================
`default_nettype none

module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NSTEP = WIDTH / DIGIT;
    localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(NSTEP - 1);

    generate
        if ((DIGIT < 1) || (WIDTH < DIGIT) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
            $error("serial_adder: WIDTH must be a non-zero multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] s_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;
    logic             amsb_q;
    logic             bmsb_q;

    logic [DIGIT:0]   sum_d;
    logic [WIDTH-1:0] acc_d;

    assign sum_d = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};

    // Each new digit enters at the MSB end so the result is aligned after NSTEP steps.
    generate
        if (DIGIT == WIDTH) begin : g_single
            assign acc_d = sum_d[DIGIT-1:0];
        end else begin : g_multi
            assign acc_d = {sum_d[DIGIT-1:0], acc_q[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b ^ {WIDTH{sub}};
                        carry_q <= sub;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                        amsb_q  <= a[WIDTH-1];
                        bmsb_q  <= b[WIDTH-1] ^ sub;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc_q   <= acc_d;
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    carry_q <= sum_d[DIGIT];
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == C_LAST) begin
                        s_q     <= acc_d;
                        cout_q  <= sum_d[DIGIT];
                        ovf_q   <= (amsb_q == bmsb_q) && (sum_d[DIGIT-1] != amsb_q);
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_RUN);
    assign out_valid = (state_q == S_DONE);
    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
//==============================================================================
// Module   : tb_serial_adder
// Brief    : Directed checks of serial_adder at 8/2, 32/4 and 16/16.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance 0: 8/2, instance 1: 32/4, instance 2: 16/16
    logic        iv   [3];
    logic        ordy [3];
    logic        sb   [3];
    logic [31:0] av   [3];
    logic [31:0] bv   [3];
    logic        irdy [3];
    logic        ovd  [3];
    logic        co   [3];
    logic        of   [3];
    logic        bz   [3];
    logic [7:0]  s0;
    logic [31:0] s1;
    logic [15:0] s2;

    serial_adder #(.WIDTH(8), .DIGIT(2)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]),
        .a(av[0][7:0]), .b(bv[0][7:0]), .sub(sb[0]), .out_valid(ovd[0]),
        .out_ready(ordy[0]), .s(s0), .cout(co[0]), .ovf(of[0]), .busy(bz[0])
    );

    serial_adder #(.WIDTH(32), .DIGIT(4)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]),
        .a(av[1]), .b(bv[1]), .sub(sb[1]), .out_valid(ovd[1]),
        .out_ready(ordy[1]), .s(s1), .cout(co[1]), .ovf(of[1]), .busy(bz[1])
    );

    serial_adder #(.WIDTH(16), .DIGIT(16)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]),
        .a(av[2][15:0]), .b(bv[2][15:0]), .sub(sb[2]), .out_valid(ovd[2]),
        .out_ready(ordy[2]), .s(s2), .cout(co[2]), .ovf(of[2]), .busy(bz[2])
    );

    function automatic logic [31:0] sval(input int sel);
        case (sel)
            0:       return {24'd0, s0};
            1:       return s1;
            default: return {16'd0, s2};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered and left at #1 after a rising edge with the selected unit idle.
    task automatic op(input int sel, input logic [31:0] ta, input logic [31:0] tb_,
                      input logic tsub, input logic [31:0] es, input logic ec,
                      input logic eo, input int nstep, input logic release_out,
                      input string tag);
        int n;
        int bcnt;
        iv[sel] = 1'b1;
        av[sel] = ta;
        bv[sel] = tb_;
        sb[sel] = tsub;
        @(posedge clk); #1;
        iv[sel] = 1'b0;
        chk({tag, ".in_ready_run"}, {31'd0, irdy[sel]}, 32'd0);
        n    = 0;
        bcnt = bz[sel] ? 1 : 0;
        while (!ovd[sel] && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (bz[sel]) bcnt++;
        end
        chk({tag, ".latency"}, n, nstep);
        chk({tag, ".busy_cycles"}, bcnt, nstep);
        chk({tag, ".s"}, sval(sel), es);
        chk({tag, ".cout"}, {31'd0, co[sel]}, {31'd0, ec});
        chk({tag, ".ovf"}, {31'd0, of[sel]}, {31'd0, eo});
        if (release_out) begin
            ordy[sel] = 1'b1;
            @(posedge clk); #1;
            ordy[sel] = 1'b0;
            chk({tag, ".idle_after"}, {30'd0, irdy[sel], ovd[sel]}, 32'd2);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; ordy[i] = 1'b0; sb[i] = 1'b0; av[i] = '0; bv[i] = '0;
        end

        // Reset state
        #12;
        chk("reset.flags", {28'd0, irdy[0], ovd[0], bz[0], co[0]}, 32'h8);
        chk("reset.s_ovf", {23'd0, of[0], s0}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // 8-bit directed vectors
        op(0, 32'hFF, 32'h01, 1'b0, 32'h00, 1'b1, 1'b0, 4, 1'b1, "add_ff_01");
        op(0, 32'h7F, 32'h01, 1'b0, 32'h80, 1'b0, 1'b1, 4, 1'b1, "add_7f_01");
        op(0, 32'h05, 32'h07, 1'b1, 32'hFE, 1'b0, 1'b0, 4, 1'b1, "sub_05_07");
        op(0, 32'h80, 32'h01, 1'b1, 32'h7F, 1'b1, 1'b1, 4, 1'b1, "sub_80_01");
        op(0, 32'h00, 32'h00, 1'b1, 32'h00, 1'b1, 1'b0, 4, 1'b1, "sub_00_00");

        // Backpressure: result held, new operands ignored
        op(0, 32'h3C, 32'h11, 1'b0, 32'h4D, 1'b0, 1'b0, 4, 1'b0, "bp_3c_11");
        iv[0] = 1'b1; av[0] = 32'h01; bv[0] = 32'h01; sb[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp.hold", {21'd0, irdy[0], ovd[0], bz[0], s0}, {24'd0, 8'h4D} | 32'h200);
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        chk("bp.release", {21'd0, irdy[0], ovd[0], bz[0], s0}, 32'h44D);
        @(posedge clk); #1;
        chk("bp.no_start", {30'd0, irdy[0], bz[0]}, 32'd2);

        // Asynchronous reset in RUN step 2
        iv[0] = 1'b1; av[0] = 32'hAA; bv[0] = 32'h55; sb[0] = 1'b0;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        @(posedge clk); #2;
        chk("abort.busy_before", {31'd0, bz[0]}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort.flags", {28'd0, irdy[0], ovd[0], bz[0], co[0]}, 32'h8);
        chk("abort.s_ovf", {23'd0, of[0], s0}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        op(0, 32'h10, 32'h20, 1'b0, 32'h30, 1'b0, 1'b0, 4, 1'b1, "post_abort");

        // 32/4 unit
        op(1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 8, 1'b1, "w32_add_ovf");
        op(1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 32'h7777_7788, 1'b0, 1'b0, 8, 1'b1, "w32_sub");
        op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0, 8, 1'b1, "w32_add_ff");

        // 16/16 unit: single RUN step
        op(2, 32'h8000, 32'h8000, 1'b0, 32'h0000, 1'b1, 1'b1, 1, 1'b1, "w16_add_ovf");
        op(2, 32'h1234, 32'h1234, 1'b1, 32'h0000, 1'b1, 1'b0, 1, 1'b1, "w16_sub_eq");
        op(2, 32'h0003, 32'h0005, 1'b1, 32'hFFFE, 1'b0, 1'b0, 1, 1'b1, "w16_sub_neg");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor for the Flag Vending Machine datapath; successor to the single-bit half-adder cell.
- Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, rippling the carry through a registered carry flop between digit slices.
- Gives a small, fixed-area arithmetic unit with valid/ready handshakes on both sides, for the credit and price accumulation paths.

Parameters:
WIDTH, 8, operand and result width in bits; must be an exact multiple of DIGIT and at least DIGIT.
DIGIT, 2, bits processed per RUN cycle; NSTEP = WIDTH/DIGIT.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operand set a/b/sub is presented.
in_ready  output  1  block can accept operands; high only in IDLE.
a  input  WIDTH  first operand.
b  input  WIDTH  second operand.
sub  input  1  0 = a+b, 1 = a-b (two's complement).
out_valid  output  1  result is valid and held.
out_ready  input  1  consumer accepts the result.
s  output  WIDTH  sum or difference, modulo 2^WIDTH.
cout  output  1  carry out of the MSB; for sub, 1 means no borrow (a >= b unsigned).
ovf  output  1  signed two's-complement overflow.
busy  output  1  high in RUN.

Behaviour:
- Reset: state=IDLE; in_ready=1, out_valid=0, busy=0, s=0, cout=0, ovf=0; internal operand shift registers, step counter and carry flop cleared. Reset asserted mid-RUN or mid-DONE aborts the operation; the result is discarded.
- States:
  - IDLE: in_ready=1. On in_valid=1 at an edge: latch a, b^{WIDTH{sub}} and sub; carry flop = sub; step counter = 0; go to RUN.
  - RUN: busy=1, in_ready=0. Each edge: add the low DIGIT bits of both operand shift registers plus the carry flop, shift the DIGIT-bit sum into the MSB end of the result register, shift operands right by DIGIT, update the carry flop, increment the counter.
    - On the edge where the counter reaches NSTEP-1: go to DONE, register cout = final carry, register ovf = (a[MSB]==b_eff[MSB]) && (s[MSB]!=a[MSB]).
  - DONE: out_valid=1; s/cout/ovf stable. On out_ready=1 at an edge: go to IDLE, out_valid drops next cycle. No new input is accepted in the same edge.
- Latency: the accept edge, then exactly NSTEP RUN edges; out_valid is high in cycle NSTEP+1 after the accept cycle. Throughput: one result per NSTEP+2 cycles when out_ready is held high.
- s/cout/ovf keep their last values after leaving DONE, until the next completion or reset.
- in_valid during RUN or DONE is ignored (in_ready=0); the upstream must hold it.
- out_ready outside DONE has no effect.
- Arithmetic is modulo 2^WIDTH; no saturation. When DIGIT==WIDTH, NSTEP=1.
- Parameter violation (WIDTH % DIGIT != 0) is a synthesis-time error via generate-time check.

Test Plan:
1. WIDTH=8, DIGIT=2; a=0xFF, b=0x01, sub=0 -> after 4 RUN cycles out_valid=1, s=0x00, cout=1, ovf=0, busy high exactly 4 cycles.
2. a=0x7F, b=0x01, sub=0 -> s=0x80, cout=0, ovf=1; then a=0x05, b=0x07, sub=1 -> s=0xFE, cout=0, ovf=0.
3. a=0x80, b=0x01, sub=1 -> s=0x7F, cout=1, ovf=1; a=0x00, b=0x00, sub=1 -> s=0x00, cout=1, ovf=0.
4. Backpressure: out_ready=0 for 10 cycles after completion -> out_valid and s held constant, in_ready=0, a new in_valid is ignored; out_ready=1 -> IDLE next cycle, in_ready=1.
5. rst pulsed asynchronously in RUN step 2 -> all outputs 0 immediately; after release, a=0x10, b=0x20 -> s=0x30 with no residue from the aborted operation.
6. Random soak with WIDTH=32, DIGIT=4 and WIDTH=16, DIGIT=16, random stalls on both sides -> every s/cout/ovf matches a reference model; latency is always NSTEP+1 cycles to out_valid.
